udp_type_pack: RTL and testbench

- Transmit-side counterpart of the UDP command splitter.
- Frames responses from two producers into the UDP TX byte stream, using the same header layout the splitter parses:
  - bytes 0-2: sync
  - byte 3: type
  - byte 4: channel
  - bytes 5-6: payload length, big-endian
  - byte 7 onward: payload
- Producer A is the scope sample stream (type 0). Producer B is status/ack (types 4/5).
- The output feeds the UDP/IP TX engine.

---
 rtl/udp_proto_pkg.sv | 53 +++++
 rtl/udp_type_pack_if.sv | 19 +
 rtl/udp_rr_arb2.sv | 38 +++
 rtl/udp_type_pack.sv | 159 +++++++++++++++
 tb/tb_udp_type_pack.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_proto_pkg.sv
// Shared UDP framing constants for the command splitter and the type packer.
// Header: sync[3], type, channel, len_hi, len_lo, then payload.
package udp_proto_pkg;

    localparam logic [23:0] SYNC    = 24'h55AA5A;
    localparam int          HDR_LEN = 7;
    localparam int          MAX_LEN = 1024;

    typedef enum logic [7:0] {
        T_SCOPE  = 8'd0,
        T_CUSTOM = 8'd1,
        T_MUSIC  = 8'd2,
        T_CIPHER = 8'd3,
        T_UART   = 8'd4,
        T_UPDATA = 8'd5
    } pkt_type_e;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OFF_SYNC0 = 3'd0;
    localparam logic [2:0] OFF_SYNC1 = 3'd1;
    localparam logic [2:0] OFF_SYNC2 = 3'd2;
    localparam logic [2:0] OFF_TYPE  = 3'd3;
    localparam logic [2:0] OFF_CHAN  = 3'd4;
    localparam logic [2:0] OFF_LENH  = 3'd5;
    localparam logic [2:0] OFF_LENL  = 3'd6;

    function automatic logic [7:0] hdr_byte(
        input logic [2:0]  idx,
        input logic [23:0] sync,
        input logic [7:0]  ty,
        input logic [7:0]  ch,
        input logic [15:0] len
    );
        logic [7:0] b;
        unique case (idx)
            OFF_SYNC0: b = sync[23:16];
            OFF_SYNC1: b = sync[15:8];
            OFF_SYNC2: b = sync[7:0];
            OFF_TYPE:  b = ty;
            OFF_CHAN:  b = ch;
            OFF_LENH:  b = len[15:8];
            OFF_LENL:  b = len[7:0];
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udp_type_pack_if.sv
// Byte stream from the type packer to the UDP/IP TX engine.
// udp_len is the total UDP payload length, valid for the whole packet.
interface udp_type_pack_if;
    logic [15:0] udp_len;
    logic [7:0]  udp_data;
    logic        udp_valid;
    logic        udp_last;
    logic        udp_ready;

    modport master (
        output udp_len, udp_data, udp_valid, udp_last,
        input  udp_ready
    );

    modport slave (
        input  udp_len, udp_data, udp_valid, udp_last,
        output udp_ready
    );
endinterface

// File: rtl/udp_rr_arb2.sv
// Two-way round-robin arbiter; grants only while enabled, then latches
// which side won and flips priority to the other side.
module udp_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b,
    output logic o_sel_b
);
    logic prio_b_q, prio_b_d;
    logic sel_b_q, sel_b_d;

    always_comb begin
        o_gnt_b  = i_en & i_req_b & (~i_req_a | prio_b_q);
        o_gnt_a  = i_en & i_req_a & ~o_gnt_b;
        prio_b_d = prio_b_q;
        sel_b_d  = sel_b_q;
        if (o_gnt_a | o_gnt_b) begin
            sel_b_d  = o_gnt_b;
            prio_b_d = o_gnt_a;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio_b_q <= 1'b0;
            sel_b_q  <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
            sel_b_q  <= sel_b_d;
        end
    end

    assign o_sel_b = sel_b_q;
endmodule

// File: rtl/udp_type_pack.sv
// Frames scope (A) and status/ack (B) responses into the UDP TX stream.
// Single output register; header bytes then payload, last on final byte.
module udp_type_pack
    import udp_proto_pkg::*;
#(
    parameter logic [23:0] P_SYNC    = SYNC,
    parameter int          P_MAX_LEN = MAX_LEN,
    parameter int          P_HDR_LEN = HDR_LEN
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_a_req,
    input  logic [7:0]  i_a_type,
    input  logic [7:0]  i_a_channel,
    input  logic [15:0] i_a_len,
    output logic        o_a_ack,
    input  logic [7:0]  i_a_data,
    input  logic        i_a_valid,
    output logic        o_a_ready,
    input  logic        i_b_req,
    input  logic [7:0]  i_b_type,
    input  logic [7:0]  i_b_channel,
    input  logic [15:0] i_b_len,
    output logic        o_b_ack,
    input  logic [7:0]  i_b_data,
    input  logic        i_b_valid,
    output logic        o_b_ready,
    udp_type_pack_if.master tx,
    output logic        o_busy,
    output logic        o_err
);
    localparam logic [2:0] HDR_END = 3'(P_HDR_LEN - 1);

    logic [2:0]  st_q, st_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  ty_q, ty_d, ch_q, ch_d;
    logic [15:0] len_q, len_d, rem_q, rem_d;
    logic [15:0] ulen_q, ulen_d;
    logic [7:0]  dat_q, dat_d;
    logic        vld_q, vld_d, last_q, last_d;

    logic        gnt_a, gnt_b, gnt, sel_b;
    logic [7:0]  sel_ty, sel_ch, pay_dat;
    logic [15:0] sel_len;
    logic        too_long, ld, pay_rdy, pay_go;

    udp_rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (st_q == S_ARB),
        .i_req_a (i_a_req),
        .i_req_b (i_b_req),
        .o_gnt_a (gnt_a),
        .o_gnt_b (gnt_b),
        .o_sel_b (sel_b)
    );

    assign gnt      = gnt_a | gnt_b;
    assign sel_ty   = gnt_b ? i_b_type : i_a_type;
    assign sel_ch   = gnt_b ? i_b_channel : i_a_channel;
    assign sel_len  = gnt_b ? i_b_len : i_a_len;
    assign too_long = 32'(sel_len) > 32'(P_MAX_LEN);

    // Output register may load when empty or being drained this cycle.
    assign ld      = ~vld_q | tx.udp_ready;
    assign pay_rdy = (st_q == S_PAY) & ld;
    assign pay_dat = sel_b ? i_b_data : i_a_data;
    assign pay_go  = pay_rdy & (sel_b ? i_b_valid : i_a_valid);

    assign o_a_ready = pay_rdy & ~sel_b;
    assign o_b_ready = pay_rdy & sel_b;
    assign o_a_ack   = gnt_a;
    assign o_b_ack   = gnt_b;
    assign o_err     = gnt & too_long;
    assign o_busy    = st_q != S_IDLE;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        ty_d   = ty_q;
        ch_d   = ch_q;
        len_d  = len_q;
        rem_d  = rem_q;
        ulen_d = ulen_q;
        dat_d  = dat_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (ld) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
        unique case (st_q)
            S_IDLE: if (i_a_req | i_b_req) st_d = S_ARB;
            S_ARB: begin
                st_d = S_IDLE;
                if (gnt && !too_long) begin
                    ty_d   = sel_ty;
                    ch_d   = sel_ch;
                    len_d  = sel_len;
                    rem_d  = sel_len;
                    ulen_d = sel_len + 16'(P_HDR_LEN);
                    cnt_d  = 3'd0;
                    st_d   = S_HDR;
                end
            end
            S_HDR: if (ld) begin
                dat_d = hdr_byte(cnt_q, P_SYNC, ty_q, ch_q, len_q);
                vld_d = 1'b1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == HDR_END) begin
                    last_d = len_q == 16'd0;
                    st_d   = (len_q == 16'd0) ? S_DONE : S_PAY;
                end
            end
            S_PAY: if (pay_go) begin
                dat_d = pay_dat;
                vld_d = 1'b1;
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) begin
                    last_d = 1'b1;
                    st_d   = S_DONE;
                end
            end
            S_DONE: if (vld_q & last_q & tx.udp_ready) st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q   <= S_IDLE;
            cnt_q  <= 3'd0;
            ty_q   <= 8'd0;
            ch_q   <= 8'd0;
            len_q  <= 16'd0;
            rem_q  <= 16'd0;
            ulen_q <= 16'd0;
            dat_q  <= 8'd0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            ty_q   <= ty_d;
            ch_q   <= ch_d;
            len_q  <= len_d;
            rem_q  <= rem_d;
            ulen_q <= ulen_d;
            dat_q  <= dat_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign tx.udp_len   = ulen_q;
    assign tx.udp_data  = dat_q;
    assign tx.udp_valid = vld_q;
    assign tx.udp_last  = last_q;
endmodule

// File: tb/tb_udp_type_pack.sv
// Randomized bench for udp_type_pack: producers, TX sink and a packet model.
// Received stream is compared byte-for-byte against model-built packets.
module tb_udp_type_pack;
    localparam logic [23:0] SYNC_E = 24'h55AA5A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 0, b_req = 0;
    logic [7:0]  a_type = 0, a_ch = 0, b_type = 0, b_ch = 0;
    logic [15:0] a_len = 0, b_len = 0;
    logic [7:0]  a_data = 0, b_data = 0;
    logic        a_valid = 0, b_valid = 0;
    logic        a_ack, b_ack, a_ready, b_ready, busy, err;

    udp_type_pack_if bus ();

    udp_type_pack dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_a_req     (a_req),
        .i_a_type    (a_type),
        .i_a_channel (a_ch),
        .i_a_len     (a_len),
        .o_a_ack     (a_ack),
        .i_a_data    (a_data),
        .i_a_valid   (a_valid),
        .o_a_ready   (a_ready),
        .i_b_req     (b_req),
        .i_b_type    (b_type),
        .i_b_channel (b_ch),
        .i_b_len     (b_len),
        .o_b_ack     (b_ack),
        .i_b_data    (b_data),
        .i_b_valid   (b_valid),
        .o_b_ready   (b_ready),
        .tx          (bus),
        .o_busy      (busy),
        .o_err       (err)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0]  got_q[$], exp_q[$];
    logic [15:0] glen_q[$], elen_q[$];
    logic [7:0]  pay_a[$], pay_b[$];
    int n_aack = 0, n_back = 0, n_errp = 0, n_orphan = 0;
    bit b_rdy_seen = 0, abort = 0, last_b = 0;
    int rmode = 0, cyc = 0, last_cyc = 0, last_gap = 99;
    bit in_gap = 0;

    // TX sink ready pattern: 0 always ready, 1 toggling, 2 random
    initial begin
        bus.udp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.udp_ready = 1'b1;
                1: bus.udp_ready = ~bus.udp_ready;
                default: bus.udp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: capture accepted bytes, hold-stability, ack/err pulses
    initial begin
        bit hv;
        logic [7:0] hd;
        logic hl;
        hv = 0; hd = 0; hl = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hv = 0;
                in_gap = 0;
            end else begin
                if (hv) begin
                    chk("hold_valid", 32'(bus.udp_valid), 1);
                    chk("hold_data", 32'(bus.udp_data), 32'(hd));
                    chk("hold_last", 32'(bus.udp_last), 32'(hl));
                end
                hv = bus.udp_valid && !bus.udp_ready;
                hd = bus.udp_data;
                hl = bus.udp_last;
                if (bus.udp_valid && in_gap) begin
                    last_gap = cyc - last_cyc - 1;
                    in_gap = 0;
                end
                if (bus.udp_valid && bus.udp_ready) begin
                    got_q.push_back({bus.udp_last, bus.udp_data});
                    if (bus.udp_last) begin
                        glen_q.push_back(bus.udp_len);
                        last_cyc = cyc;
                        in_gap = 1;
                    end
                end
                if (a_ack) n_aack++;
                if (b_ack) n_back++;
                if (err) begin
                    n_errp++;
                    if (!(a_ack || b_ack)) n_orphan++;
                end
                if (b_ready) b_rdy_seen = 1;
            end
        end
    end

    // Reference packet: sync, type, channel, big-endian length, payload
    task automatic model_pkt(input logic [7:0] ty, input logic [7:0] ch,
                             input logic [15:0] len, input logic [7:0] pay[$]);
        logic [7:0] h[7];
        h[0] = 8'(SYNC_E / 65536);
        h[1] = 8'((SYNC_E / 256) % 256);
        h[2] = 8'(SYNC_E % 256);
        h[3] = ty;
        h[4] = ch;
        h[5] = 8'(len / 256);
        h[6] = 8'(len % 256);
        for (int k = 0; k < 7; k++)
            exp_q.push_back({(k == 6 && len == 0), h[k]});
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back({(i == int'(len) - 1), pay[i]});
        elen_q.push_back(len + 16'd7);
    endtask

    task automatic set_pay(input bit sb, input logic [7:0] d, input logic v);
        if (sb) begin b_data = d; b_valid = v; end
        else begin a_data = d; a_valid = v; end
    endtask

    task automatic produce(input bit sb, input logic [7:0] ty, input logic [7:0] ch,
                           input logic [15:0] len, input int vpct, input int gap_at);
        int n, i, gl;
        bit acc;
        logic [7:0] p[$];
        p = sb ? pay_b : pay_a;
        if (sb) begin b_type = ty; b_ch = ch; b_len = len; b_req = 1; end
        else begin a_type = ty; a_ch = ch; a_len = len; a_req = 1; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb ? b_ack : a_ack) && n < 4000 && !abort);
        if (!abort) chk(sb ? "ack_b_seen" : "ack_a_seen", 32'(sb ? b_ack : a_ack), 1);
        @(posedge clk);
        #1;
        if (sb) b_req = 0; else a_req = 0;
        if (len > 16'd1024) return;
        i = 0; n = 0; gl = 0;
        if (len > 0) set_pay(sb, p[0], $urandom_range(0, 99) < vpct);
        while (i < int'(len) && n < 4000 && !abort) begin
            @(negedge clk);
            n++;
            acc = sb ? (b_valid && b_ready) : (a_valid && a_ready);
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                if (i == gap_at) gl = 3;
            end
            if (i < int'(len)) begin
                if (gl > 0) begin
                    set_pay(sb, p[i], 1'b0);
                    gl--;
                end else set_pay(sb, p[i], $urandom_range(0, 99) < vpct);
            end else set_pay(sb, 8'h00, 1'b0);
        end
        set_pay(sb, 8'h00, 1'b0);
        if (!abort) chk("pay_done", i, 32'(len));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 4000);
        chk("idle_reached", 32'(busy), 0);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("%s_b%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
        chk({tag, "_npkts"}, glen_q.size(), elen_q.size());
        for (int k = 0; k < elen_q.size() && k < glen_q.size(); k++)
            chk($sformatf("%s_len%0d", tag, k), 32'(glen_q[k]), 32'(elen_q[k]));
        got_q.delete(); exp_q.delete(); glen_q.delete(); elen_q.delete();
    endtask

    task automatic rand_pay(input bit sb, input int len);
        if (sb) pay_b.delete(); else pay_a.delete();
        for (int i = 0; i < len; i++)
            if (sb) pay_b.push_back(8'($urandom)); else pay_a.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] tys[3];
        int la, lb, ln;
        bit sb;
        logic [7:0] ty;
        tys[0] = 8'd0; tys[1] = 8'd4; tys[2] = 8'd5;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.udp_valid), 0);
        chk("rst_last", 32'(bus.udp_last), 0);
        chk("rst_data", 32'(bus.udp_data), 0);
        chk("rst_len", 32'(bus.udp_len), 0);
        chk("rst_ctl", {busy, err, a_ack, b_ack, a_ready, b_ready}, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // A: 3-byte scope packet
        rmode = 0;
        pay_a = '{8'h11, 8'h22, 8'h33};
        n_aack = 0;
        model_pkt(8'd0, 8'd2, 16'd3, pay_a);
        produce(0, 8'd0, 8'd2, 16'd3, 100, -1);
        wait_idle();
        check_stream("a3");
        chk("a3_acks", n_aack, 1);

        // B: zero-length status, ready must never assert
        b_rdy_seen = 0; n_back = 0;
        pay_b.delete();
        model_pkt(8'd4, 8'd7, 16'd0, pay_b);
        produce(1, 8'd4, 8'd7, 16'd0, 100, -1);
        wait_idle();
        check_stream("b0");
        chk("b0_ready_seen", 32'(b_rdy_seen), 0);
        chk("b0_acks", n_back, 1);
        last_b = 1;

        // Simultaneous requests, round-robin order
        for (int r = 0; r < 2; r++) begin
            la = $urandom_range(1, 6); lb = $urandom_range(1, 6);
            rand_pay(0, la); rand_pay(1, lb);
            n_aack = 0; n_back = 0;
            if (last_b) begin
                model_pkt(8'd0, 8'd1, 16'(la), pay_a);
                model_pkt(8'd5, 8'd3, 16'(lb), pay_b);
            end else begin
                model_pkt(8'd5, 8'd3, 16'(lb), pay_b);
                model_pkt(8'd0, 8'd1, 16'(la), pay_a);
            end
            last_b = last_b ? 1'b1 : 1'b0;
            fork
                produce(0, 8'd0, 8'd1, 16'(la), 100, -1);
                produce(1, 8'd5, 8'd3, 16'(lb), 100, -1);
            join
            wait_idle();
            check_stream($sformatf("rr%0d", r));
            chk("rr_a_acks", n_aack, 1);
            chk("rr_b_acks", n_back, 1);
            chk("rr_gap_min", 32'(last_gap >= 2), 1);
        end

        // Toggling ready, 3-cycle producer stall mid-payload
        rmode = 1;
        rand_pay(0, 4);
        n_aack = 0;
        model_pkt(8'd0, 8'd9, 16'd4, pay_a);
        produce(0, 8'd0, 8'd9, 16'd4, 100, 2);
        wait_idle();
        check_stream("tog");
        chk("tog_acks", n_aack, 1);

        // Random traffic with random ready and valid
        rmode = 2;
        for (int r = 0; r < 5; r++) begin
            sb = 1'($urandom_range(0, 1));
            ln = $urandom_range(0, 20);
            ty = tys[$urandom_range(0, 2)];
            rand_pay(sb, ln);
            model_pkt(ty, 8'(r), 16'(ln), sb ? pay_b : pay_a);
            produce(sb, ty, 8'(r), 16'(ln), 70, -1);
            wait_idle();
        end
        check_stream("rnd");

        // Oversize request is rejected; boundary length accepted
        rmode = 0;
        n_aack = 0; n_errp = 0; n_orphan = 0;
        produce(0, 8'd0, 8'd1, 16'd1025, 100, -1);
        repeat (4) @(negedge clk);
        chk("err_pulses", n_errp, 1);
        chk("err_without_ack", n_orphan, 0);
        chk("err_acks", n_aack, 1);
        chk("err_no_bytes", got_q.size(), 0);
        chk("err_idle", 32'(busy), 0);
        rand_pay(0, 1024);
        model_pkt(8'd0, 8'd1, 16'd1024, pay_a);
        produce(0, 8'd0, 8'd1, 16'd1024, 100, -1);
        wait_idle();
        chk("max_err_pulses", n_errp, 1);
        check_stream("max");

        // Reset during payload byte 2
        rand_pay(0, 8);
        fork
            produce(0, 8'd0, 8'd2, 16'd8, 100, -1);
            begin
                int n;
                n = 0;
                while (got_q.size() < 9 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                chk("mid_reached", 32'(got_q.size() >= 9), 1);
                @(posedge clk);
                #3;
                rst_n = 0;
                abort = 1;
                #1;
                chk("mrst_valid", 32'(bus.udp_valid), 0);
                chk("mrst_last", 32'(bus.udp_last), 0);
                chk("mrst_data", 32'(bus.udp_data), 0);
                chk("mrst_len", 32'(bus.udp_len), 0);
                chk("mrst_ctl", {busy, err, a_ack, b_ack, a_ready, b_ready}, 0);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        a_req = 0; a_valid = 0; abort = 0;
        got_q.delete(); glen_q.delete(); exp_q.delete(); elen_q.delete();
        rst_n = 1;
        rand_pay(0, 5);
        n_aack = 0;
        model_pkt(8'd0, 8'd2, 16'd5, pay_a);
        produce(0, 8'd0, 8'd2, 16'd5, 100, -1);
        wait_idle();
        check_stream("post_rst");
        chk("post_rst_acks", n_aack, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
